musa_trace_buffer: RTL and testbench
====================================

# musa_trace_buffer

Synthesizable, parametrised trace capture unit for the MUSA core. It records per-cycle datapath samples (instruction word plus packed control flags: pcSrc, memRead, memWrite, push, pop, aluOp, regWrite, memToReg, regDst) into a circular buffer. Capture is controlled by a trigger, with a configurable pre-trigger window, and the captured window is read out oldest-first over a simple request/valid port. It sits beside `dataPath` and gives silicon and FPGA builds the same visibility that the simulation monitor gives in the testbench.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width
- CTRL_WIDTH, 12, packed control-flag width
- DEPTH, 16, buffer entries; power of two, ≥4
- PRE_TRIGGER, 4, entries kept before the trigger sample; range 0..DEPTH-1

Ports:
- clk  in  1  core clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- arm  in  1  start capture; honoured only in IDLE
- abort  in  1  return to IDLE from any state; highest priority after rst
- trig_mode  in  2  0 IMMEDIATE, 1 INSTR_MATCH, 2 MEM_WRITE, 3 MATCH_AND_REGWRITE
- trig_value  in  DATA_WIDTH  instruction compare value
- trig_mask  in  DATA_WIDTH  compare mask; bit=1 means compared
- sample_valid  in  1  a sample is present this cycle
- sample_instr  in  DATA_WIDTH  instruction sample
- sample_ctrl  in  CTRL_WIDTH  control sample; bit positions are defined in the package
- rd_req  in  1  request the next entry
- rd_valid  out  1  rd_data is valid
- rd_data  out  CTRL_WIDTH+DATA_WIDTH  {ctrl, instr}
- rd_last  out  1  marks the final entry; coincident with rd_valid
- done  out  1  capture complete; high in DONE only
- busy  out  1  high in ARMED or POST
- count  out  $clog2(DEPTH)+1  number of valid entries captured

## Operation
- States: IDLE → ARMED → POST → DONE → READ → IDLE.
- IDLE:
  - `arm` clears the pointers, `count` and `pre_seen`, then moves to ARMED.
- ARMED:
  - Every valid sample is written at `wr_ptr`, and `wr_ptr` increments with wrap.
  - `pre_seen` saturates at PRE_TRIGGER.
  - Trigger is evaluated on the current sample:
    - IMMEDIATE: any valid sample.
    - INSTR_MATCH: `(instr & mask) == (value & mask)`.
    - MEM_WRITE: memWrite flag.
    - MATCH_AND_REGWRITE: INSTR_MATCH and regWrite flag.
  - On trigger, the trigger sample is written and `post_left` is loaded with DEPTH-PRE_TRIGGER-1. The next state is POST, or DONE if `post_left` is 0.
- POST:
  - Each valid sample is written and decrements `post_left`.
  - The write that takes `post_left` from 1 to 0 moves the block to DONE.
- `count` = `pre_seen` + 1 + post samples written. The maximum is DEPTH.
- Read start pointer = `trig_ptr` - `pre_seen`, modulo DEPTH. Samples older than the pre-window are never read.
- DONE/READ:
  - Each `rd_req` returns the next entry.
  - The entry at index `count`-1 carries `rd_last`. The state then returns to IDLE.
  - `rd_req` outside DONE/READ is ignored.
- `arm` outside IDLE is ignored.
- `sample_valid` outside ARMED/POST is ignored.
- `abort` or `rst` mid-operation discards the capture. All outputs go to reset values. RAM contents are don't-care.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `rd_last`=0, `done`=0, `busy`=0, `count`=0, state IDLE.
- `arm` is sampled at edge N. The state is ARMED from N+1, so the first capturable sample is at edge N+1.
- Samples are written on the edge where `sample_valid`=1. Gaps in `sample_valid` do not advance pointers.
- `done` rises the cycle after the final post write edge.
- Read latency is 1 cycle: `rd_req` at edge N gives `rd_valid`/`rd_data` during N+1 (synchronous RAM read). `rd_req` may be held high, giving one entry per cycle.
- The state is IDLE the cycle after the `rd_last` beat. `rd_req` during the `rd_last` cycle is ignored.
- `abort` and `arm` in the same cycle: `abort` wins.

## Structure
- Package `musa_trace_pkg`:
  - state enum
  - trig_mode enum
  - ctrl bit-position constants (MEMWRITE_BIT, REGWRITE_BIT, …)
  - entry-width function
- Sub-module `musa_trace_ram`: simple dual-port RAM, DEPTH × (CTRL_WIDTH+DATA_WIDTH), with one write port, one registered read port, and no reset on the array.

## Test plan
All scenarios use DEPTH=8, PRE_TRIGGER=3.
- INSTR_MATCH, value 0x0A, mask 0xFFFFFFFF; `arm`, then instr 1..20 with `sample_valid` continuous → `done`, `count`=8; readout 7,8,9,10,11,12,13,14, with `rd_last` on 14.
- Same setup with value 0x02 → `count`=6; readout 1..6, with `rd_last` on 6.
- IMMEDIATE; instr 0x100..0x10F with `sample_valid` low on alternate cycles → `count`=5; readout 0x100..0x104.
- MEM_WRITE; memWrite set only on instr 0x33 within stream 0x30..0x40 → readout 0x30..0x37.
- `abort` in POST → IDLE next cycle, `busy`=0, `count`=0; re-arm succeeds.
- `rst` asserted mid-readout (after 3 beats) → all outputs 0 immediately; `arm` after release starts a fresh capture.

Source files
------------

// File: rtl/musa_trace_buffer_pkg.sv
// Shared types and constants for the MUSA trace capture unit.
// Control-flag bit positions describe how dataPath packs sample_ctrl.
package musa_trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_POST,
        ST_DONE,
        ST_READ
    } state_e;

    typedef enum logic [1:0] {
        TRIG_IMMEDIATE          = 2'd0,
        TRIG_INSTR_MATCH        = 2'd1,
        TRIG_MEM_WRITE          = 2'd2,
        TRIG_MATCH_AND_REGWRITE = 2'd3
    } trig_mode_e;

    // Layout: {pcSrc[1:0], memRead, memWrite, push, pop, aluOp[2:0], regWrite, memToReg, regDst}
    localparam int REGDST_BIT   = 0;
    localparam int MEMTOREG_BIT = 1;
    localparam int REGWRITE_BIT = 2;
    localparam int ALUOP_LSB    = 3;
    localparam int POP_BIT      = 6;
    localparam int PUSH_BIT     = 7;
    localparam int MEMWRITE_BIT = 8;
    localparam int MEMREAD_BIT  = 9;
    localparam int PCSRC_LSB    = 10;

    function automatic int entry_width(input int data_w, input int ctrl_w);
        return data_w + ctrl_w;
    endfunction

endpackage

// File: rtl/musa_trace_buffer_if.sv
// Control, sample and readout signals of the trace buffer grouped as one bus.
interface musa_trace_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 12,
    parameter int DEPTH      = 16
);
    import musa_trace_pkg::*;

    localparam int EW = entry_width(DATA_WIDTH, CTRL_WIDTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  arm;
    logic                  abort;
    logic [1:0]            trig_mode;
    logic [DATA_WIDTH-1:0] trig_value;
    logic [DATA_WIDTH-1:0] trig_mask;
    logic                  sample_valid;
    logic [DATA_WIDTH-1:0] sample_instr;
    logic [CTRL_WIDTH-1:0] sample_ctrl;
    logic                  rd_req;
    logic                  rd_valid;
    logic [EW-1:0]         rd_data;
    logic                  rd_last;
    logic                  done;
    logic                  busy;
    logic [CW-1:0]         count;

    modport master (
        output arm, abort, trig_mode, trig_value, trig_mask,
               sample_valid, sample_instr, sample_ctrl, rd_req,
        input  rd_valid, rd_data, rd_last, done, busy, count
    );

    modport slave (
        input  arm, abort, trig_mode, trig_value, trig_mask,
               sample_valid, sample_instr, sample_ctrl, rd_req,
        output rd_valid, rd_data, rd_last, done, busy, count
    );
endinterface

// File: rtl/musa_trace_buffer_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// The array is deliberately not reset; only the read-out gating defines outputs.
module musa_trace_ram #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/musa_trace_buffer.sv
// Trigger-driven circular trace capture with a pre-trigger window and
// oldest-first readout.
//   state    | meaning
//   IDLE     | waiting for arm
//   ARMED    | capturing pre-trigger history, evaluating trigger
//   POST     | capturing post-trigger samples until buffer is full
//   DONE     | capture complete, waiting for first rd_req
//   READ     | streaming entries until the rd_last beat
module musa_trace_buffer
    import musa_trace_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CTRL_WIDTH  = 12,
    parameter int DEPTH       = 16,
    parameter int PRE_TRIGGER = 4
) (
    input logic               clk,
    input logic               rst,
    musa_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = entry_width(DATA_WIDTH, CTRL_WIDTH);
    localparam logic [CW-1:0] POST_INIT = CW'(DEPTH - PRE_TRIGGER - 1);
    localparam logic [CW-1:0] PRE_MAX   = CW'(PRE_TRIGGER);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] rd_idx_q, rd_idx_d;
    logic [CW-1:0] pre_seen_q, pre_seen_d;
    logic [CW-1:0] post_left_q, post_left_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;

    logic          wr_en;
    logic          rd_fire;
    logic          trig_hit;
    logic          instr_match;
    logic [EW-1:0] ram_rdata;

    always_comb begin
        instr_match = ((bus.sample_instr ^ bus.trig_value) & bus.trig_mask) == '0;
        case (trig_mode_e'(bus.trig_mode))
            TRIG_IMMEDIATE:          trig_hit = 1'b1;
            TRIG_INSTR_MATCH:        trig_hit = instr_match;
            TRIG_MEM_WRITE:          trig_hit = bus.sample_ctrl[MEMWRITE_BIT];
            TRIG_MATCH_AND_REGWRITE: trig_hit = instr_match && bus.sample_ctrl[REGWRITE_BIT];
            default:                 trig_hit = 1'b0;
        endcase
    end

    assign wr_en   = bus.sample_valid && !bus.abort
                     && (state_q == ST_ARMED || state_q == ST_POST);
    // The rd_last beat swallows any request presented alongside it.
    assign rd_fire = bus.rd_req && !bus.abort
                     && (state_q == ST_DONE || (state_q == ST_READ && !rd_last_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (bus.arm) state_d = ST_ARMED;
                ST_ARMED: if (wr_en && trig_hit) state_d = (POST_INIT == '0) ? ST_DONE : ST_POST;
                ST_POST:  if (wr_en && post_left_q == CW'(1)) state_d = ST_DONE;
                ST_DONE:  if (rd_fire) state_d = ST_READ;
                ST_READ:  if (rd_last_q) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.done     = (state_q == ST_DONE);
        bus.busy     = (state_q == ST_ARMED) || (state_q == ST_POST);
        bus.count    = count_q;
        bus.rd_valid = rd_valid_q;
        bus.rd_last  = rd_last_q;
        bus.rd_data  = rd_valid_q ? ram_rdata : '0;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_idx_d    = rd_idx_q;
        pre_seen_d  = pre_seen_q;
        post_left_d = post_left_q;
        count_d     = count_q;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        if (bus.abort) begin
            count_d = '0;
        end else begin
            if (state_q == ST_IDLE && bus.arm) begin
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                rd_idx_d   = '0;
                pre_seen_d = '0;
                count_d    = '0;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (state_q == ST_ARMED) begin
                    if (trig_hit) begin
                        // Oldest readable entry sits pre_seen slots behind the trigger.
                        rd_ptr_d    = wr_ptr_q - pre_seen_q[AW-1:0];
                        post_left_d = POST_INIT;
                        count_d     = pre_seen_q + CW'(1);
                    end else begin
                        if (pre_seen_q != PRE_MAX) pre_seen_d = pre_seen_q + CW'(1);
                        count_d = pre_seen_d;
                    end
                end else begin
                    post_left_d = post_left_q - CW'(1);
                    count_d     = count_q + CW'(1);
                end
            end
            if (rd_fire) begin
                rd_valid_d = 1'b1;
                rd_last_d  = (rd_idx_q == count_q - CW'(1));
                rd_ptr_d   = rd_ptr_q + AW'(1);
                rd_idx_d   = rd_idx_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_idx_q    <= '0;
            pre_seen_q  <= '0;
            post_left_q <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_idx_q    <= rd_idx_d;
            pre_seen_q  <= pre_seen_d;
            post_left_q <= post_left_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    musa_trace_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({bus.sample_ctrl, bus.sample_instr}),
        .re_i    (rd_fire),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );
endmodule

// File: tb/tb_musa_trace_buffer.sv
// Scoreboard bench for musa_trace_buffer: stimulus pushes expected readout
// beats, a negedge monitor pops and compares every rd_valid beat.
module tb_musa_trace_buffer;
    localparam int DW = 32;
    localparam int CWD = 12;
    localparam int DEPTH = 8;
    localparam int PRE = 3;
    localparam logic [31:0] NO_MW = 32'hFFFF_FFFF;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [44:0] exp_q[$];

    musa_trace_buffer_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CWD), .DEPTH(DEPTH)) dif ();

    musa_trace_buffer #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CWD), .DEPTH(DEPTH), .PRE_TRIGGER(PRE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [11:0] mk_ctrl(input logic [31:0] ins, input logic [31:0] mw);
        logic hit;
        hit = (ins == mw);
        return {3'b000, hit, ins[7:0]};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Monitor: every beat must match the head of the scoreboard; idle data must be zero.
    always @(negedge clk) begin
        if (!rst) begin
            if (dif.rd_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got last=%0b data=%0h want no beat",
                             dif.rd_last, dif.rd_data);
                end else begin
                    logic [44:0] e;
                    e = exp_q.pop_front();
                    if ({dif.rd_last, dif.rd_data} !== e) begin
                        n_err++;
                        $display("FAIL beat: got last=%0b data=%0h want last=%0b data=%0h",
                                 dif.rd_last, dif.rd_data, e[44], e[43:0]);
                    end
                end
            end else begin
                n_cmp++;
                if (dif.rd_data !== '0 || dif.rd_last !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_outputs: got data=%0h last=%0b want 0/0",
                             dif.rd_data, dif.rd_last);
                end
            end
        end
    end

    task automatic expect_range(input logic [31:0] first, input int n, input logic [31:0] mw);
        logic [31:0] ins;
        logic        last;
        for (int i = 0; i < n; i++) begin
            ins  = first + 32'(i);
            last = (i == n - 1);
            exp_q.push_back({last, mk_ctrl(ins, mw), ins});
        end
    endtask

    task automatic capture(input logic [1:0] mode, input logic [31:0] val,
                           input logic [31:0] first, input int n, input bit gaps,
                           input logic [31:0] mw);
        logic [31:0] ins;
        dif.trig_mode  = mode;
        dif.trig_value = val;
        dif.trig_mask  = 32'hFFFF_FFFF;
        dif.arm = 1'b1;
        @(posedge clk); #1;
        dif.arm = 1'b0;
        check("busy_after_arm", dif.busy, 1);
        for (int i = 0; i < n; i++) begin
            ins = first + 32'(i);
            dif.sample_valid = 1'b1;
            dif.sample_instr = ins;
            dif.sample_ctrl  = mk_ctrl(ins, mw);
            @(posedge clk); #1;
            if (gaps) begin
                dif.sample_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        dif.sample_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 40; i++) begin
            if (dif.done) break;
            @(posedge clk); #1;
        end
        check({nm, "_done"}, dif.done, 1);
        check({nm, "_busy_low"}, dif.busy, 0);
    endtask

    task automatic readout(input string nm);
        int guard;
        guard = 0;
        dif.rd_req = 1'b1;
        while (exp_q.size() != 0 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        dif.rd_req = 1'b0;
        check({nm, "_drained"}, 64'(exp_q.size()), 0);
        check({nm, "_idle_done"}, dif.done, 0);
        check({nm, "_idle_busy"}, dif.busy, 0);
        exp_q.delete();
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        dif.arm = 1'b0;
        dif.abort = 1'b0;
        dif.trig_mode = 2'd0;
        dif.trig_value = '0;
        dif.trig_mask = '0;
        dif.sample_valid = 1'b0;
        dif.sample_instr = '0;
        dif.sample_ctrl = '0;
        dif.rd_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_valid", dif.rd_valid, 0);
        check("rst_rd_data", dif.rd_data, 0);
        check("rst_rd_last", dif.rd_last, 0);
        check("rst_done", dif.done, 0);
        check("rst_busy", dif.busy, 0);
        check("rst_count", dif.count, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Instruction match deep in the stream: full 8-entry window.
        capture(2'd1, 32'h0A, 32'd1, 20, 1'b0, NO_MW);
        wait_done("t1");
        check("t1_count", dif.count, 8);
        expect_range(32'd7, 8, NO_MW);
        readout("t1");

        // Early match: only one pre-trigger sample available.
        capture(2'd1, 32'h02, 32'd1, 20, 1'b0, NO_MW);
        wait_done("t2");
        check("t2_count", dif.count, 6);
        expect_range(32'd1, 6, NO_MW);
        readout("t2");

        // Immediate trigger with sample_valid gaps.
        capture(2'd0, 32'h0, 32'h100, 16, 1'b1, NO_MW);
        wait_done("t3");
        check("t3_count", dif.count, 5);
        expect_range(32'h100, 5, NO_MW);
        readout("t3");

        // memWrite flag trigger.
        capture(2'd2, 32'h0, 32'h30, 17, 1'b0, 32'h33);
        wait_done("t4");
        check("t4_count", dif.count, 8);
        expect_range(32'h30, 8, 32'h33);
        readout("t4");

        // Abort while in POST, then abort+arm together, then a clean re-arm.
        dif.trig_mode = 2'd0;
        dif.arm = 1'b1;
        @(posedge clk); #1;
        dif.arm = 1'b0;
        dif.sample_valid = 1'b1;
        dif.sample_instr = 32'h55;
        dif.sample_ctrl  = mk_ctrl(32'h55, NO_MW);
        @(posedge clk); #1;
        dif.sample_valid = 1'b0;
        check("t5_post_busy", dif.busy, 1);
        check("t5_post_count", dif.count, 1);
        dif.abort = 1'b1;
        @(posedge clk); #1;
        dif.abort = 1'b0;
        check("t5_abort_busy", dif.busy, 0);
        check("t5_abort_count", dif.count, 0);
        check("t5_abort_done", dif.done, 0);
        dif.arm = 1'b1;
        dif.abort = 1'b1;
        @(posedge clk); #1;
        dif.arm = 1'b0;
        dif.abort = 1'b0;
        check("t5_abort_wins", dif.busy, 0);
        capture(2'd1, 32'h02, 32'd1, 20, 1'b0, NO_MW);
        wait_done("t5");
        check("t5_count", dif.count, 6);
        expect_range(32'd1, 6, NO_MW);
        readout("t5");

        // Reset during readout after three beats.
        capture(2'd1, 32'h0A, 32'd1, 20, 1'b0, NO_MW);
        wait_done("t6");
        expect_range(32'd7, 8, NO_MW);
        dif.rd_req = 1'b1;
        guard = 0;
        while (exp_q.size() > 5 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check("t6_three_beats", 64'(exp_q.size()), 5);
        rst = 1'b1;
        #1;
        check("t6_rst_rd_valid", dif.rd_valid, 0);
        check("t6_rst_rd_data", dif.rd_data, 0);
        check("t6_rst_rd_last", dif.rd_last, 0);
        check("t6_rst_done", dif.done, 0);
        check("t6_rst_busy", dif.busy, 0);
        check("t6_rst_count", dif.count, 0);
        exp_q.delete();
        dif.rd_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        capture(2'd0, 32'h0, 32'h100, 16, 1'b1, NO_MW);
        wait_done("t6b");
        check("t6b_count", dif.count, 5);
        expect_range(32'h100, 5, NO_MW);
        readout("t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
